// File: rtl/accel_incr_engine.sv
// -----------------------------------------------------------------------------
// accel_incr_engine
//
// Purpose: walks SRAM words 0..N-1 and adds a small unsigned increment to each
// one (read, wait for data, write back). The engine shares a single-port SRAM
// with a host. The host owns the SRAM while the engine is idle or finishing,
// and loses access while a run is in flight.
//
// Ports:
//   clk          - single clock, rising edge
//   rst_n        - synchronous active-low reset
//   start        - level run request, only looked at while idle
//   max_cnt      - number of words N to process (starting at word 0)
//   incr         - unsigned increment, zero-extended to the data width
//   done         - one-cycle completion pulse
//   accel_state  - registered FSM state code
//   accel_error  - registered error code of the current / last run
//   host_*       - host word-addressed memory request / read data
//   sram_*       - single-port SRAM request / read data (1-cycle read latency)
// -----------------------------------------------------------------------------
module accel_incr_engine #(
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int MEM_DATA_WIDTH = 32,
  parameter int MEM_DEPTH      = 1024
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [7:0]                  max_cnt,
  input  logic [7:0]                  incr,
  output logic                        done,
  output logic [3:0]                  accel_state,
  output logic [3:0]                  accel_error,
  input  logic                        host_en,
  input  logic [MEM_ADDR_WIDTH-1:0]   host_addr,
  input  logic                        host_we,
  input  logic [MEM_DATA_WIDTH/8-1:0] host_be,
  input  logic [MEM_DATA_WIDTH-1:0]   host_wdata,
  output logic [MEM_DATA_WIDTH-1:0]   host_rdata,
  output logic                        sram_en,
  output logic [MEM_ADDR_WIDTH-1:0]   sram_addr,
  output logic                        sram_we,
  output logic [MEM_DATA_WIDTH/8-1:0] sram_be,
  output logic [MEM_DATA_WIDTH-1:0]   sram_wdata,
  input  logic [MEM_DATA_WIDTH-1:0]   sram_rdata
);

  localparam int BE_W  = MEM_DATA_WIDTH / 8;
  // Common width for comparing the word index against N and the depth.
  localparam int CMP_W = (MEM_ADDR_WIDTH + 1 > 8) ? MEM_ADDR_WIDTH + 1 : 8;
  localparam logic [CMP_W-1:0] DEPTH_C = CMP_W'(MEM_DEPTH);

  localparam logic [3:0] ERR_NONE      = 4'd0;
  localparam logic [3:0] ERR_ZERO_CNT  = 4'd1;
  localparam logic [3:0] ERR_RANGE     = 4'd2;
  localparam logic [3:0] ERR_COLLISION = 4'd3;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_READ  = 4'd1,
    S_WAIT  = 4'd2,
    S_WRITE = 4'd3,
    S_DONE  = 4'd4
  } state_t;

  state_t                    state_reg, state_next;
  logic [MEM_ADDR_WIDTH-1:0] k_reg, k_next;
  logic [3:0]                err_reg, err_next;
  logic                      done_reg, done_next;
  logic [MEM_DATA_WIDTH-1:0] sum_reg, sum_next;
  logic [7:0]                n_reg, n_next;
  logic [7:0]                incr_reg, incr_next;

  logic [BE_W-1:0]           be_ones;
  logic                      busy;
  logic                      last_word;

  genvar gi;
  generate
    for (gi = 0; gi < BE_W; gi++) begin : g_be_ones
      assign be_ones[gi] = 1'b1;
    end
  endgenerate

  assign busy        = (state_reg == S_READ) || (state_reg == S_WAIT) ||
                       (state_reg == S_WRITE);
  // k+1 == N avoids the underflow that k == N-1 would need care with.
  assign last_word   = ((CMP_W'(k_reg) + CMP_W'(1)) == CMP_W'(n_reg));
  assign accel_state = state_reg;
  assign accel_error = err_reg;
  assign done        = done_reg;

  always_comb begin
    state_next = state_reg;
    k_next     = k_reg;
    err_next   = err_reg;
    done_next  = 1'b0;
    sum_next   = sum_reg;
    n_next     = n_reg;
    incr_next  = incr_reg;

    // Host owns the SRAM unless a run is in flight.
    sram_en    = host_en;
    sram_addr  = host_addr;
    sram_we    = host_we;
    sram_be    = host_be;
    sram_wdata = host_wdata;
    host_rdata = sram_rdata;

    if (busy) begin
      sram_en    = 1'b0;
      sram_addr  = '0;
      sram_we    = 1'b0;
      sram_be    = '0;
      sram_wdata = '0;
      host_rdata = '0;
      // Host request is dropped; flag it unless an error is already recorded.
      if (host_en && (err_reg == ERR_NONE)) begin
        err_next = ERR_COLLISION;
      end
    end

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          err_next  = ERR_NONE;
          k_next    = '0;
          n_next    = max_cnt;
          incr_next = incr;
          if (max_cnt == 8'd0) begin
            err_next   = ERR_ZERO_CNT;
            state_next = S_DONE;
          end else if (CMP_W'(max_cnt) > DEPTH_C) begin
            err_next   = ERR_RANGE;
            state_next = S_DONE;
          end else begin
            state_next = S_READ;
          end
        end
      end
      S_READ: begin
        sram_en    = 1'b1;
        sram_we    = 1'b0;
        sram_addr  = k_reg;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        // Carry out of the top bit is intentionally discarded.
        sum_next   = sram_rdata + MEM_DATA_WIDTH'(incr_reg);
        state_next = S_WRITE;
      end
      S_WRITE: begin
        sram_en    = 1'b1;
        sram_we    = 1'b1;
        sram_be    = be_ones;
        sram_addr  = k_reg;
        sram_wdata = sum_reg;
        if (last_word) begin
          state_next = S_DONE;
        end else begin
          k_next     = k_reg + MEM_ADDR_WIDTH'(1);
          state_next = S_READ;
        end
      end
      S_DONE: begin
        // Registered pulse: visible in the cycle after DONE.
        done_next  = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      k_reg     <= '0;
      err_reg   <= ERR_NONE;
      done_reg  <= 1'b0;
      sum_reg   <= '0;
      n_reg     <= '0;
      incr_reg  <= '0;
    end else begin
      state_reg <= state_next;
      k_reg     <= k_next;
      err_reg   <= err_next;
      done_reg  <= done_next;
      sum_reg   <= sum_next;
      n_reg     <= n_next;
      incr_reg  <= incr_next;
    end
  end

endmodule

// File: doc/accel_incr_engine.md
ACCEL_INCR_ENGINE -- requirements
Module: accel_incr_engine

Interface
REQ-001 SHALL have parameter MEM_ADDR_WIDTH, default 10, meaning the word address width of host and SRAM ports.
REQ-002 SHALL have parameter MEM_DATA_WIDTH, default 32, meaning the data width; byte-enable width is MEM_DATA_WIDTH/8.
REQ-003 SHALL have parameter MEM_DEPTH, default 1024, meaning the number of SRAM words.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  level request from control word 0 bit 0; sampled only in IDLE.
REQ-007 max_cnt  input  8  number of words N to process, starting at word address 0.
REQ-008 incr  input  8  unsigned increment, zero-extended to MEM_DATA_WIDTH.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 accel_state  output  4  current FSM state code.
REQ-011 accel_error  output  4  error code of current or last run.
REQ-012 host_en, host_addr, host_we, host_be, host_wdata  input  1/MEM_ADDR_WIDTH/1/MEM_DATA_WIDTH/8/MEM_DATA_WIDTH  host word-addressed memory request.
REQ-013 host_rdata  output  MEM_DATA_WIDTH  host read data, one cycle after the read request.
REQ-014 sram_en, sram_addr, sram_we, sram_be, sram_wdata  output  same widths as host request  single-port SRAM request.
REQ-015 sram_rdata  input  MEM_DATA_WIDTH  SRAM read data, valid one cycle after an accepted read.

Function
REQ-016 State codes SHALL be IDLE=0, READ=1, WAIT=2, WRITE=3, DONE=4; accel_state SHALL equal the registered state.
REQ-017 Error codes SHALL be NONE=0, ZERO_CNT=1, RANGE=2, HOST_COLLISION=3; accel_error SHALL be registered.
REQ-018 IDLE with start=1: accel_error SHALL clear to NONE; next state READ if 1<=N<=MEM_DEPTH, DONE with ZERO_CNT if N=0, DONE with RANGE if N>MEM_DEPTH; index k SHALL reset to 0.
REQ-019 READ SHALL drive sram_en=1, sram_we=0, sram_addr=k, then go to WAIT.
REQ-020 WAIT SHALL drive sram_en=0 and capture sram_rdata+incr (modulo 2^MEM_DATA_WIDTH, carry discarded), then go to WRITE.
REQ-021 WRITE SHALL drive sram_en=1, sram_we=1, sram_be all ones, sram_addr=k, sram_wdata=captured sum; if k=N-1 go to DONE, else k<=k+1 and go to READ.
REQ-022 DONE SHALL assert done=1 for exactly one cycle, then go to IDLE unconditionally.
REQ-023 With start sampled at edge t, done SHALL be high in the cycle following edge t+3N+1 for valid N, and following edge t+1 for error cases.
REQ-024 start SHALL be ignored outside IDLE; start still high on return to IDLE SHALL begin a new run.
REQ-025 In IDLE and DONE, sram_* SHALL pass host_* through combinationally; host_rdata SHALL equal sram_rdata.
REQ-026 In READ/WAIT/WRITE, host requests SHALL be dropped (not forwarded); host_en=1 SHALL set accel_error to HOST_COLLISION unless already nonzero; run SHALL continue; host_rdata SHALL be 0.
REQ-027 Errors SHALL be sticky until the next accepted start.
REQ-028 k SHALL be MEM_ADDR_WIDTH wide; comparisons with N SHALL zero-extend both to max(8, MEM_ADDR_WIDTH+1) bits.

Reset
REQ-029 rst_n=0 at a clock edge SHALL force state IDLE, k=0, accel_error=NONE, done=0, captured sum=0, regardless of state.
REQ-030 During and immediately after reset, sram_* SHALL reflect host pass-through; a run aborted by reset SHALL leave already-written words modified and remaining words untouched.

Verification
REQ-031 mem[0..3]={10,20,30,0xFFFFFFFF}, max_cnt=4, incr=5, start=1 -> mem={15,25,35,4}; done one pulse 13 cycles after start sampled; error 0.
REQ-032 max_cnt=0, start=1 -> DONE next cycle, done pulse, accel_error=1, no SRAM access.
REQ-033 MEM_DEPTH=16, max_cnt=17 -> accel_error=2, no SRAM access; max_cnt=16 -> all 16 words updated, error 0.
REQ-034 Host write to addr 2 during WAIT of run max_cnt=4 -> write dropped, accel_error=3, run completes, mem[2] = original+incr.
REQ-035 rst_n=0 during WRITE of k=1 (max_cnt=4) -> state IDLE, done never pulses, mem[0..1] updated, mem[2..3] unchanged, error 0.
REQ-036 start held high across done -> second run begins one cycle after IDLE entry; each word incremented twice.
